rgf_writeback: RTL and testbench

//  Writer end of the register-file write port (we/wn/data). Merges single-cycle ALU results and

---
 rtl/rgf_writeback.sv | 141 ++++++++++++++
 tb/tb_rgf_writeback.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rgf_writeback.sv
// Register-file write port arbiter: merges 1-cycle ALU results with FIFO-buffered long-latency
// results into one registered write per cycle, and tracks long-op destinations in a busy bitmap.
module rgf_writeback #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic [31:0]     busy,
    output logic            we,
    output logic [4:0]      wn,
    output logic [XLEN-1:0] wdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    typedef enum logic {ALU_PRI, MEM_PRI} state_t;

    ent_t            fifo_q [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     cnt;
    state_t          state;
    logic [CW-1:0]   starve_cnt;
    logic [31:0]     busy_nxt;
    ent_t            head;
    logic            empty, full, push, pop, alu_win;

    assign empty     = (cnt == '0);
    assign full      = (cnt == (AW+1)'(DEPTH));
    assign mem_ready = !full;
    assign alu_ready = (state == ALU_PRI);
    assign head      = fifo_q[rptr];
    assign push      = mem_valid && mem_ready;
    assign alu_win   = alu_ready && alu_valid;
    // In MEM_PRI the ALU cannot win, so the head drains whenever the FIFO holds anything.
    assign pop       = !empty && !alu_win;

    // Storage needs no reset: only the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr] <= '{rd: mem_rd, data: mem_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ALU_PRI;
            starve_cnt <= '0;
        end else begin
            case (state)
                ALU_PRI: begin
                    if (alu_valid && !empty) begin
                        if (starve_cnt == CW'(STARVE_MAX-1)) begin
                            state      <= MEM_PRI;
                            starve_cnt <= '0;
                        end else begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                MEM_PRI: begin
                    state      <= ALU_PRI;
                    starve_cnt <= '0;
                end
                default: begin
                    state      <= ALU_PRI;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

    // x0 writes are consumed silently; wn/wdata keep their last real write.
    always_ff @(posedge clk) begin
        if (rst) begin
            we    <= 1'b0;
            wn    <= '0;
            wdata <= '0;
        end else begin
            we <= 1'b0;
            if (alu_win) begin
                if (alu_rd != 5'd0) begin
                    we    <= 1'b1;
                    wn    <= alu_rd;
                    wdata <= alu_data;
                end
            end else if (pop) begin
                if (head.rd != 5'd0) begin
                    we    <= 1'b1;
                    wn    <= head.rd;
                    wdata <= head.data;
                end
            end
        end
    end

    // Set after clear so a same-cycle reissue of the retiring register stays pending.
    always_comb begin
        busy_nxt = busy;
        if (pop && head.rd != 5'd0)      busy_nxt[head.rd] = 1'b0;
        if (iss_valid && iss_rd != 5'd0) busy_nxt[iss_rd]  = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end
endmodule

// File: tb/tb_rgf_writeback.sv
// Directed vector bench for rgf_writeback: table of per-cycle inputs with hand-computed
// expected ready flags (before the edge) and registered outputs (after the edge).
module tb_rgf_writeback;
    logic        clk, rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready, iss_valid, we;
    logic [4:0]  alu_rd, mem_rd, iss_rd, wn;
    logic [31:0] alu_data, mem_data, busy, wdata;

    int tests = 0;
    int fails = 0;

    rgf_writeback #(.XLEN(32), .DEPTH(4), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy(busy), .we(we), .wn(wn), .wdata(wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        iv;
        logic [4:0]  ird;
        logic        e_ardy;
        logic        e_mrdy;
        logic        e_we;
        logic [4:0]  e_wn;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t row(
        input logic rst_i, input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
        input logic iv, input logic [4:0] ird,
        input logic ea, input logic em, input logic ew, input logic [4:0] ewn,
        input logic [31:0] ewd, input logic [31:0] eb);
        vec_t v;
        v.rst = rst_i; v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv; v.mrd = mrd; v.md = md; v.iv = iv; v.ird = ird;
        v.e_ardy = ea; v.e_mrdy = em; v.e_we = ew; v.e_wn = ewn; v.e_wd = ewd; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0; iss_valid = 1'b0; iss_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.we",        32'(we),        32'd0);
        chk("reset.busy",      busy,           32'd0);
        chk("reset.mem_ready", 32'(mem_ready), 32'd1);
        chk("reset.alu_ready", 32'(alu_ready), 32'd1);
        chk("reset.wn",        32'(wn),        32'd0);
        chk("reset.wdata",     wdata,          32'd0);

        //            rst av ard  adata      mv mrd  mdata     iv ird  ardy mrdy we wn  wdata      busy
        // basic ALU write, then scoreboard round trip on x7
        vq.push_back(row(0, 1, 5,  32'h11,   0, 0,  0,        0, 0,   1, 1, 1, 5,  32'h11,  32'h0));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 0, 0,  0,       32'h0));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        1, 7,   1, 1, 0, 0,  0,       32'h80));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 0, 0,  0,       32'h80));
        vq.push_back(row(0, 0, 0,  0,        1, 7,  32'hAB,   0, 0,   1, 1, 0, 0,  0,       32'h80));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 1, 7,  32'hAB,  32'h0));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 0, 0,  0,       32'h0));
        // ALU write to x0 is swallowed
        vq.push_back(row(0, 1, 0,  32'h55,   0, 0,  0,        0, 0,   1, 1, 0, 0,  0,       32'h0));
        // fill FIFO behind continuous ALU traffic; 5th push refused; guard fires
        vq.push_back(row(0, 1, 1,  32'h101,  1, 10, 32'hA0,   0, 0,   1, 1, 1, 1,  32'h101, 32'h0));
        vq.push_back(row(0, 1, 2,  32'h102,  1, 11, 32'hA1,   0, 0,   1, 1, 1, 2,  32'h102, 32'h0));
        vq.push_back(row(0, 1, 3,  32'h103,  1, 12, 32'hA2,   0, 0,   1, 1, 1, 3,  32'h103, 32'h0));
        vq.push_back(row(0, 1, 4,  32'h104,  1, 13, 32'hA3,   0, 0,   1, 1, 1, 4,  32'h104, 32'h0));
        vq.push_back(row(0, 1, 5,  32'h105,  1, 14, 32'hEE,   0, 0,   1, 0, 1, 5,  32'h105, 32'h0));
        vq.push_back(row(0, 1, 6,  32'h106,  1, 14, 32'hEE,   0, 0,   0, 0, 1, 10, 32'hA0,  32'h0));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 1, 11, 32'hA1,  32'h0));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 1, 12, 32'hA2,  32'h0));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 1, 13, 32'hA3,  32'h0));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 0, 0,  0,       32'h0));
        // starvation: one entry, four ALU wins, one forced pop, ALU resumes
        vq.push_back(row(0, 0, 0,  0,        1, 9,  32'h99,   1, 9,   1, 1, 0, 0,  0,       32'h200));
        vq.push_back(row(0, 1, 1,  32'h201,  0, 0,  0,        0, 0,   1, 1, 1, 1,  32'h201, 32'h200));
        vq.push_back(row(0, 1, 2,  32'h202,  0, 0,  0,        0, 0,   1, 1, 1, 2,  32'h202, 32'h200));
        vq.push_back(row(0, 1, 3,  32'h203,  0, 0,  0,        0, 0,   1, 1, 1, 3,  32'h203, 32'h200));
        vq.push_back(row(0, 1, 4,  32'h204,  0, 0,  0,        0, 0,   1, 1, 1, 4,  32'h204, 32'h200));
        vq.push_back(row(0, 1, 5,  32'h205,  0, 0,  0,        0, 0,   0, 1, 1, 9,  32'h99,  32'h0));
        vq.push_back(row(0, 1, 5,  32'h205,  0, 0,  0,        0, 0,   1, 1, 1, 5,  32'h205, 32'h0));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 0, 0,  0,       32'h0));
        // reissue of x3 in the same cycle its long result pops: bit stays set
        vq.push_back(row(0, 0, 0,  0,        1, 3,  32'h33,   1, 3,   1, 1, 0, 0,  0,       32'h8));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        1, 3,   1, 1, 1, 3,  32'h33,  32'h8));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 0, 0,  0,       32'h8));
        // reset in the middle of draining
        vq.push_back(row(0, 1, 1,  32'h301,  1, 20, 32'hC0,   1, 20,  1, 1, 1, 1,  32'h301, 32'h100008));
        vq.push_back(row(0, 1, 2,  32'h302,  1, 21, 32'hC1,   0, 0,   1, 1, 1, 2,  32'h302, 32'h100008));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 1, 20, 32'hC0,  32'h8));
        vq.push_back(row(1, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 0, 0,  0,       32'h0));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 0, 0,  0,       32'h0));
        vq.push_back(row(0, 0, 0,  0,        0, 0,  0,        0, 0,   1, 1, 0, 0,  0,       32'h0));

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst;
            alu_valid = vq[i].av; alu_rd = vq[i].ard; alu_data = vq[i].ad;
            mem_valid = vq[i].mv; mem_rd = vq[i].mrd; mem_data = vq[i].md;
            iss_valid = vq[i].iv; iss_rd = vq[i].ird;
            #1;
            chk($sformatf("v%0d.alu_ready", i), 32'(alu_ready), 32'(vq[i].e_ardy));
            chk($sformatf("v%0d.mem_ready", i), 32'(mem_ready), 32'(vq[i].e_mrdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.we", i), 32'(we), 32'(vq[i].e_we));
            if (vq[i].e_we) begin
                chk($sformatf("v%0d.wn", i),    32'(wn), 32'(vq[i].e_wn));
                chk($sformatf("v%0d.wdata", i), wdata,   vq[i].e_wd);
            end
            chk($sformatf("v%0d.busy", i), busy, vq[i].e_busy);
        end

        @(negedge clk);
        rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
